// File: rtl/tlm_stream_pkg.sv
// tlm_stream_pkg: shared state encoding, operand byte layout and item extraction for tlm_batch_streamer
package tlm_stream_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;
  localparam int A_LSB = 0;
  localparam int B_LSB = 8;
  localparam int BYTE_W = 8;
  localparam int MAX_BATCH_W = 8192;
  function automatic logic [2*BYTE_W-1:0] item_ab(input logic [MAX_BATCH_W-1:0] batch, input int k, input int item_w);
    logic [MAX_BATCH_W-1:0] s;
    s = batch >> (k * item_w);
    return {s[B_LSB +: BYTE_W], s[A_LSB +: BYTE_W]};
  endfunction
endpackage

// File: rtl/tlm_batch_streamer.sv
// tlm_batch_streamer: takes one packed batch (batch_valid_i/batch_ready_o), streams items as A_s/B_s bytes (item_valid_o/item_ready_i), pulses done_o and counts batches in batch_cnt_o
module tlm_batch_streamer
  import tlm_stream_pkg::*;
#(
  parameter int NUM = 100,
  parameter int ITEM_WIDTH = 16,
  localparam int IDX_W = NUM > 1 ? $clog2(NUM) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      batch_valid_i,
  output logic                      batch_ready_o,
  input  logic [NUM*ITEM_WIDTH-1:0] batch_data_i,
  output logic [BYTE_W-1:0]         A_s,
  output logic [BYTE_W-1:0]         B_s,
  output logic                      item_valid_o,
  input  logic                      item_ready_i,
  output logic [IDX_W-1:0]          item_idx_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [31:0]               batch_cnt_o
);
  state_e state_q, state_d;
  logic [NUM*ITEM_WIDTH-1:0] buf_q;
  logic beat, last;
  always_comb begin
    beat = state_q == STREAM && item_ready_i;
    last = item_idx_o == IDX_W'(NUM - 1);
    state_d = state_q == IDLE ? (batch_valid_i ? STREAM : IDLE) :
              state_q == STREAM ? (beat && last ? DONE : STREAM) : IDLE;
  end
  assign batch_ready_o = state_q == IDLE;
  assign item_valid_o = state_q == STREAM;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      A_s <= '0;
      B_s <= '0;
      item_idx_o <= '0;
      batch_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && batch_valid_i) begin
        buf_q <= batch_data_i;
        {B_s, A_s} <= item_ab(MAX_BATCH_W'(batch_data_i), 0, ITEM_WIDTH);
        item_idx_o <= '0;
      end
      if (beat && !last) begin
        item_idx_o <= item_idx_o + 1'b1;
        {B_s, A_s} <= item_ab(MAX_BATCH_W'(buf_q), int'(item_idx_o) + 1, ITEM_WIDTH);
      end
      if (state_q == DONE) begin
        batch_cnt_o <= batch_cnt_o + 32'd1;
        item_idx_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_tlm_batch_streamer.sv
// tb_tlm_batch_streamer: scoreboard bench for tlm_batch_streamer (NUM=100 instance plus a NUM=1, 24-bit instance)
module tb_tlm_batch_streamer;
  localparam int NUM = 100;
  localparam int IW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bv, br, iv, ir, busy, done;
  logic [NUM*IW-1:0] data;
  logic [7:0] a, b;
  logic [6:0] idx;
  logic [31:0] cnt;
  logic bv1, br1, iv1, ir1, busy1, done1;
  logic [23:0] data1;
  logic [7:0] a1, b1;
  logic [0:0] idx1;
  logic [31:0] cnt1;
  int checks = 0, errors = 0, cyc = 0, t_acc = 0, done_seen = 0, d0 = 0, rel = 0;
  logic [22:0] sb[$];
  logic p_stall = 1'b0;
  logic [22:0] p_out = '0;
  tlm_batch_streamer #(.NUM(NUM), .ITEM_WIDTH(IW)) u0 (
    .clk_i(clk), .reset_i(rst), .batch_valid_i(bv), .batch_ready_o(br), .batch_data_i(data),
    .A_s(a), .B_s(b), .item_valid_o(iv), .item_ready_i(ir), .item_idx_o(idx),
    .busy_o(busy), .done_o(done), .batch_cnt_o(cnt)
  );
  tlm_batch_streamer #(.NUM(1), .ITEM_WIDTH(24)) u1 (
    .clk_i(clk), .reset_i(rst), .batch_valid_i(bv1), .batch_ready_o(br1), .batch_data_i(data1),
    .A_s(a1), .B_s(b1), .item_valid_o(iv1), .item_ready_i(ir1), .item_idx_o(idx1),
    .busy_o(busy1), .done_o(done1), .batch_cnt_o(cnt1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (p_stall && iv) check("stall_hold", 32'({idx, b, a}), 32'(p_out));
    p_stall = iv && !ir;
    p_out = {idx, b, a};
    if (iv && ir) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got beat %0h expected none", {idx, b, a});
      end else check("item", 32'({idx, b, a}), 32'(sb.pop_front()));
    end
    if (done) done_seen++;
  end
  task automatic push_batch();
    for (int k = 0; k < NUM; k++) sb.push_back({7'(k), 8'(k + 128), 8'(k)});
  endtask
  task automatic accept(input bit hold);
    bv = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bv = 1'b0;
    t_acc = cyc;
  endtask
  task automatic run_until_done(input bit rnd, output int r);
    r = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        r = cyc - t_acc + 1;
        return;
      end
      @(posedge clk);
      #1;
      if (rnd) ir = 1'($urandom_range(0, 1));
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done_o expected one within 2000 cycles");
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end
  initial begin
    bv = 1'b0;
    ir = 1'b1;
    bv1 = 1'b0;
    ir1 = 1'b1;
    data1 = 24'hFF_A5_3C;
    for (int k = 0; k < NUM; k++) data[k*IW +: IW] = {8'(k + 128), 8'(k)};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", iv, 0);
    check("rst_ab", {b, a}, 0);
    check("rst_idx", idx, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", br, 1);
    d0 = done_seen;
    push_batch();
    accept(0);
    run_until_done(0, rel);
    check("t1_done_cycle", rel, NUM + 1);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_ready_back", br, 1);
    check("t1_cnt", cnt, 1);
    check("t1_sb_drained", sb.size(), 0);
    check("t1_idx_reset", idx, 0);
    check("t1_last_ab", {b, a}, 16'hE363);
    push_batch();
    accept(0);
    run_until_done(1, rel);
    ir = 1'b1;
    @(posedge clk);
    #1;
    check("t2_cnt", cnt, 2);
    check("t2_sb_drained", sb.size(), 0);
    check("t12_done_pulses", done_seen - d0, 2);
    rst = 1'b1;
    bv = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bv = 1'b0;
    @(negedge clk);
    check("rstoffer_valid", iv, 0);
    check("rstoffer_busy", busy, 0);
    check("rstoffer_cnt", cnt, 0);
    d0 = done_seen;
    for (int n = 0; n < 3; n++) push_batch();
    accept(1);
    @(negedge clk);
    check("t3_ready_low", br, 0);
    check("t3_busy", busy, 1);
    run_until_done(0, rel);
    check("t3_done_cycle", rel, NUM + 1);
    @(negedge clk);
    check("t3_ready_t102", br, 1);
    @(negedge clk);
    check("t3_second_accept", {iv, br, 1'b0, idx}, {1'b1, 1'b0, 1'b0, 7'd0});
    run_until_done(0, rel);
    run_until_done(0, rel);
    bv = 1'b0;
    @(posedge clk);
    #1;
    check("t3_cnt", cnt, 3);
    check("t3_done_pulses", done_seen - d0, 3);
    check("t3_sb_drained", sb.size(), 0);
    @(posedge clk);
    #1;
    check("t3_no_fourth", busy, 0);
    push_batch();
    d0 = done_seen;
    accept(0);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t4_valid", iv, 0);
    check("t4_ab", {b, a}, 0);
    check("t4_idx", idx, 0);
    check("t4_done", done, 0);
    check("t4_cnt", cnt, 0);
    @(posedge clk);
    #1;
    check("t4_no_done", done_seen - d0, 0);
    push_batch();
    accept(0);
    @(negedge clk);
    check("t4_restart", {iv, idx, b, a}, {1'b1, 7'd0, 8'h80, 8'h00});
    run_until_done(0, rel);
    check("t4_done_cycle", rel, NUM + 1);
    @(negedge clk);
    check("t4_cnt", cnt, 1);
    check("t4_sb_drained", sb.size(), 0);
    bv1 = 1'b1;
    @(posedge clk);
    #1;
    bv1 = 1'b0;
    @(negedge clk);
    check("t5_valid", iv1, 1);
    check("t5_ab", {b1, a1}, 16'hA53C);
    check("t5_idx", idx1, 0);
    check("t5_no_early_done", done1, 0);
    @(negedge clk);
    check("t5_done", done1, 1);
    check("t5_valid_off", iv1, 0);
    check("t5_ab_kept", {b1, a1}, 16'hA53C);
    @(negedge clk);
    check("t5_done_pulse", done1, 0);
    check("t5_cnt", cnt1, 1);
    check("t5_ready", {br1, busy1}, 2'b10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
